// File: rtl/bus_dma.sv
// rtl/bus_dma.sv - word-copy DMA engine with register and master bus ports; define DMA_IRQ_EN to enable the completion interrupt
module bus_dma #(
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        dma_en,
  input  logic        dma_wr,
  input  logic [1:0]  dma_addr,
  input  logic [31:0] dma_data_in,
  output logic [31:0] dma_data_out,
  output logic        dma_wt,
  output logic        m_en,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_data_out,
  input  logic [31:0] m_data_in,
  input  logic        m_wt,
  output logic        irq
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Word-aligned address registers; the low two bits are implied zero.
  logic [31:2]      r_src;
  logic [31:2]      r_dst;
  logic [CNT_W-1:0] r_count;
  logic             r_busy;
  logic             r_done;
  logic             r_abort;

  // Master-side registered outputs; r_buf doubles as the copy buffer.
  logic             r_m_en;
  logic             r_m_wr;
  logic [31:0]      r_m_addr;
  logic [31:0]      r_buf;

  logic             w_reg_wr;
  logic             w_ctrl_wr;
  logic             w_start;
  logic             w_count_zero;
  logic             w_abort_req;
  logic             w_rd_done;
  logic             w_wr_done;
  logic             w_last;
  logic             w_done_nxt;
  logic             w_ien_q;

`ifdef DMA_IRQ_EN
  logic             r_ien;
  logic             r_irq;
  logic             w_ien_nxt;
`endif

  assign w_reg_wr     = dma_en & dma_wr;
  assign w_ctrl_wr    = w_reg_wr & (dma_addr == 2'd3);
  assign w_start      = w_ctrl_wr & dma_data_in[0] & ~r_busy;
  assign w_count_zero = (r_count == '0);
  // A stop request landing on the final write edge still counts as pending.
  assign w_abort_req  = w_ctrl_wr & ~dma_data_in[0] & r_busy;
  assign w_rd_done    = (r_state == S_RD) & ~m_wt;
  assign w_wr_done    = (r_state == S_WR) & ~m_wt;
  assign w_last       = w_wr_done & ((r_count == CNT_W'(1)) | r_abort | w_abort_req);

  // State register for the copy sequencer.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: a read and a write per word, no idle cycle between pairs.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start && !w_count_zero) begin
          w_state_nxt = S_RD;
        end
      end
      S_RD: begin
        if (!m_wt) begin
          w_state_nxt = S_WR;
        end
      end
      S_WR: begin
        if (!m_wt) begin
          w_state_nxt = w_last ? S_IDLE : S_RD;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // DONE: clear-on-write loses to a completion on the same edge.
  always_comb begin
    w_done_nxt = r_done;
    if (w_ctrl_wr && dma_data_in[1]) begin
      w_done_nxt = 1'b0;
    end
    if (w_start) begin
      w_done_nxt = w_count_zero;
    end
    if (w_last) begin
      w_done_nxt = 1'b1;
    end
  end

`ifdef DMA_IRQ_EN
  assign w_ien_nxt = w_ctrl_wr ? dma_data_in[2] : r_ien;
  assign w_ien_q   = r_ien;

  // Interrupt enable and interrupt flop, updated on the same edge as DONE.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ien <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      r_ien <= w_ien_nxt;
      r_irq <= w_done_nxt & w_ien_nxt;
    end
  end

  assign irq = r_irq;
`else
  assign w_ien_q = 1'b0;
  assign irq     = 1'b0;
`endif

  // Register file, transfer counters and master bus outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_src    <= '0;
      r_dst    <= '0;
      r_count  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_abort  <= 1'b0;
      r_m_en   <= 1'b0;
      r_m_wr   <= 1'b0;
      r_m_addr <= '0;
      r_buf    <= '0;
    end else begin
      r_done <= w_done_nxt;

      // Parameter registers are frozen while a copy is running.
      if (w_reg_wr && !r_busy) begin
        case (dma_addr)
          2'd0:    r_src   <= dma_data_in[31:2];
          2'd1:    r_dst   <= dma_data_in[31:2];
          2'd2:    r_count <= dma_data_in[CNT_W-1:0];
          default: ;
        endcase
      end

      if (w_start && !w_count_zero) begin
        r_busy   <= 1'b1;
        r_abort  <= 1'b0;
        r_m_en   <= 1'b1;
        r_m_wr   <= 1'b0;
        r_m_addr <= {r_src, 2'b00};
      end

      if (w_abort_req) begin
        r_abort <= 1'b1;
      end

      if (w_rd_done) begin
        r_buf    <= m_data_in;
        r_src    <= r_src + 30'd1;
        r_m_wr   <= 1'b1;
        r_m_addr <= {r_dst, 2'b00};
      end

      if (w_wr_done) begin
        r_dst   <= r_dst + 30'd1;
        r_count <= r_count - CNT_W'(1);
        r_m_wr  <= 1'b0;
        if (w_last) begin
          r_busy  <= 1'b0;
          r_abort <= 1'b0;
          r_m_en  <= 1'b0;
        end else begin
          r_m_addr <= {r_src, 2'b00};
        end
      end
    end
  end

  // Combinational register read mux; zero when the port is not selected.
  always_comb begin
    dma_data_out = 32'd0;
    if (dma_en) begin
      case (dma_addr)
        2'd0:    dma_data_out = {r_src, 2'b00};
        2'd1:    dma_data_out = {r_dst, 2'b00};
        2'd2:    dma_data_out = {{(32-CNT_W){1'b0}}, r_count};
        default: dma_data_out = {29'd0, w_ien_q, r_done, r_busy};
      endcase
    end
  end

  assign dma_wt     = 1'b0;
  assign m_en       = r_m_en;
  assign m_wr       = r_m_wr;
  assign m_size     = 2'b10;
  assign m_addr     = r_m_addr;
  assign m_data_out = r_buf;

endmodule

// File: tb/tb_bus_dma.sv
// tb/tb_bus_dma.sv - self-checking bench for bus_dma with a word memory model on the master port
module tb_bus_dma;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        dma_en;
  logic        dma_wr;
  logic [1:0]  dma_addr;
  logic [31:0] dma_data_in;
  logic [31:0] dma_data_out;
  logic        dma_wt;
  logic        m_en;
  logic        m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr;
  logic [31:0] m_data_out;
  logic [31:0] m_data_in = 32'd0;
  logic        m_wt = 1'b0;
  logic        irq;

  always #5 clk = ~clk;

  bus_dma #(.CNT_W(16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .dma_en       (dma_en),
    .dma_wr       (dma_wr),
    .dma_addr     (dma_addr),
    .dma_data_in  (dma_data_in),
    .dma_data_out (dma_data_out),
    .dma_wt       (dma_wt),
    .m_en         (m_en),
    .m_wr         (m_wr),
    .m_size       (m_size),
    .m_addr       (m_addr),
    .m_data_out   (m_data_out),
    .m_data_in    (m_data_in),
    .m_wt         (m_wt),
    .irq          (irq)
  );

  int checks = 0;
  int errors = 0;

  // Master-side model state (written only by the monitor process).
  int          wait_n = 0;
  int          wait_cnt = 0;
  int          en_cycles = 0;
  int          stab_err = 0;
  bit          irq_seen = 1'b0;
  logic [31:0] s_addr;
  logic [31:0] s_dout;
  logic        s_wr;
  logic [31:0] log_addr[$];
  logic        log_wr[$];
  logic [31:0] log_data[$];

  function automatic logic [31:0] src_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h13579BDF;
  endfunction

  // Memory model: inserts wait_n wait states per transfer, logs each completed transfer.
  always @(negedge clk) begin
    if (reset_n && m_en) begin
      if (wait_cnt == 0) begin
        s_addr = m_addr;
        s_wr   = m_wr;
        s_dout = m_data_out;
      end else if (m_addr !== s_addr || m_wr !== s_wr || (m_wr && m_data_out !== s_dout)) begin
        stab_err++;
      end
      en_cycles++;
      if (wait_cnt < wait_n) begin
        m_wt = 1'b1;
        wait_cnt++;
      end else begin
        m_wt = 1'b0;
        wait_cnt = 0;
        log_addr.push_back(m_addr);
        log_wr.push_back(m_wr);
        if (m_wr) begin
          log_data.push_back(m_data_out);
        end else begin
          m_data_in = src_word(m_addr);
          log_data.push_back(m_data_in);
        end
      end
    end else begin
      m_wt = 1'b0;
      wait_cnt = 0;
    end
    if (irq) irq_seen = 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    dma_en = 1'b1;
    dma_wr = 1'b1;
    dma_addr = a;
    dma_data_in = d;
    @(posedge clk);
    #1;
    dma_en = 1'b0;
    dma_wr = 1'b0;
  endtask

  task automatic reg_read(input logic [1:0] a, input logic en, output logic [31:0] d, output logic wt);
    dma_en = en;
    dma_wr = 1'b0;
    dma_addr = a;
    #2;
    d = dma_data_out;
    wt = dma_wt;
    dma_en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reg(input string name, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic wt;
    reg_read(a, 1'b1, d, wt);
    chk(name, d, exp);
  endtask

  task automatic wait_done(input int budget, output logic [31:0] ctrl, output logic irq_at);
    int n = 0;
    ctrl = 32'd0;
    irq_at = 1'b0;
    while (n < budget && !ctrl[1]) begin
      dma_en = 1'b1;
      dma_wr = 1'b0;
      dma_addr = 2'd3;
      #2;
      ctrl = dma_data_out;
      irq_at = irq;
      dma_en = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
    chk_bit("done_wait", ctrl[1], 1'b1);
  endtask

  task automatic check_txn(input int idx, input logic [31:0] a, input logic w, input logic [31:0] d);
    if (idx < log_addr.size()) begin
      chk($sformatf("txn%0d_addr", idx), log_addr[idx], a);
      chk_bit($sformatf("txn%0d_wr", idx), log_wr[idx], w);
      chk($sformatf("txn%0d_data", idx), log_data[idx], d);
    end else begin
      chk($sformatf("txn%0d_present", idx), 32'(log_addr.size()), 32'(idx + 1));
    end
  endtask

  typedef struct {
    int          op;    // 0 write, 1 read, 2 read with dma_en=0
    logic [1:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[16];

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic        wt;
    logic [31:0] ctrl;
    logic        irq_at;
    int          base_log;
    int          base_en;

    vecs[0]  = '{1, 2'd0, 32'h0, 32'h00000000};
    vecs[1]  = '{1, 2'd1, 32'h0, 32'h00000000};
    vecs[2]  = '{1, 2'd2, 32'h0, 32'h00000000};
    vecs[3]  = '{1, 2'd3, 32'h0, 32'h00000000};
    vecs[4]  = '{0, 2'd0, 32'h12345677, 32'h0};
    vecs[5]  = '{1, 2'd0, 32'h0, 32'h12345674};
    vecs[6]  = '{0, 2'd1, 32'hABCDEF03, 32'h0};
    vecs[7]  = '{1, 2'd1, 32'h0, 32'hABCDEF00};
    vecs[8]  = '{0, 2'd2, 32'hFFFFFFFF, 32'h0};
    vecs[9]  = '{1, 2'd2, 32'h0, 32'h0000FFFF};
    vecs[10] = '{2, 2'd0, 32'h0, 32'h00000000};
    vecs[11] = '{0, 2'd3, 32'hFFFFFFF4, 32'h0};
`ifdef DMA_IRQ_EN
    vecs[12] = '{1, 2'd3, 32'h0, 32'h00000004};
`else
    vecs[12] = '{1, 2'd3, 32'h0, 32'h00000000};
`endif
    vecs[13] = '{0, 2'd3, 32'h00000000, 32'h0};
    vecs[14] = '{1, 2'd3, 32'h0, 32'h00000000};
    vecs[15] = '{2, 2'd3, 32'h0, 32'h00000000};

    reset_n = 1'b0;
    dma_en = 1'b0;
    dma_wr = 1'b0;
    dma_addr = 2'd0;
    dma_data_in = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    chk_bit("rst_m_en", m_en, 1'b0);
    chk_bit("rst_m_wr", m_wr, 1'b0);
    chk_bit("rst_irq", irq, 1'b0);
    chk("rst_m_addr", m_addr, 32'h0);
    chk("rst_m_data_out", m_data_out, 32'h0);
    chk("m_size", {30'd0, m_size}, 32'h2);

    // Register table: reset reads, masking of low/upper bits, CTRL bits, deselected read.
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].op == 0) begin
        reg_write(vecs[i].addr, vecs[i].data);
      end else begin
        reg_read(vecs[i].addr, (vecs[i].op == 1), d, wt);
        chk($sformatf("vec%0d_rd", i), d, vecs[i].exp);
        chk_bit($sformatf("vec%0d_wt", i), wt, 1'b0);
      end
    end

    // Basic 3-word copy, no wait states.
    wait_n = 0;
    base_log = log_addr.size();
    base_en = en_cycles;
    reg_write(2'd0, 32'h00001000);
    reg_write(2'd1, 32'h00002000);
    reg_write(2'd2, 32'd3);
    reg_write(2'd3, 32'h1);
    chk_bit("start_m_en", m_en, 1'b1);
    chk("start_m_addr", m_addr, 32'h00001000);
    wait_done(100, ctrl, irq_at);
    for (int i = 0; i < 3; i++) begin
      check_txn(base_log + 2*i,     32'h1000 + 32'(4*i), 1'b0, src_word(32'h1000 + 32'(4*i)));
      check_txn(base_log + 2*i + 1, 32'h2000 + 32'(4*i), 1'b1, src_word(32'h1000 + 32'(4*i)));
    end
    chk("copy_ntxn", 32'(log_addr.size() - base_log), 32'd6);
    chk("copy_en_cycles", 32'(en_cycles - base_en), 32'd6);
    chk_reg("copy_count", 2'd2, 32'h0);
    chk_reg("copy_src", 2'd0, 32'h0000100C);
    chk_reg("copy_dst", 2'd1, 32'h0000200C);
    chk_reg("copy_ctrl", 2'd3, 32'h2);

    // Same copy with 3 wait states on every transfer.
    wait_n = 3;
    base_log = log_addr.size();
    base_en = en_cycles;
    reg_write(2'd0, 32'h00001000);
    reg_write(2'd1, 32'h00003000);
    reg_write(2'd2, 32'd3);
    reg_write(2'd3, 32'h1);
    wait_done(200, ctrl, irq_at);
    for (int i = 0; i < 3; i++) begin
      check_txn(base_log + 2*i,     32'h1000 + 32'(4*i), 1'b0, src_word(32'h1000 + 32'(4*i)));
      check_txn(base_log + 2*i + 1, 32'h3000 + 32'(4*i), 1'b1, src_word(32'h1000 + 32'(4*i)));
    end
    chk("wait_en_cycles", 32'(en_cycles - base_en), 32'd24);
    chk("wait_stable", 32'(stab_err), 32'd0);
    chk_reg("wait_count", 2'd2, 32'h0);
    chk_reg("wait_dst", 2'd1, 32'h0000300C);
    wait_n = 0;

    // Zero count: DONE immediately, no bus cycle.
    reg_write(2'd3, 32'h2);
    chk_reg("clr_done", 2'd3, 32'h0);
    base_en = en_cycles;
    reg_write(2'd2, 32'd0);
    reg_write(2'd3, 32'h1);
    chk_reg("zero_ctrl", 2'd3, 32'h2);
    repeat (4) @(posedge clk);
    #1;
    chk("zero_en_cycles", 32'(en_cycles - base_en), 32'd0);

    // Abort during the first read: exactly one word moves.
    wait_n = 2;
    base_log = log_addr.size();
    reg_write(2'd0, 32'hFFFFFFF8);
    reg_write(2'd1, 32'h00004000);
    reg_write(2'd2, 32'd4);
    reg_write(2'd3, 32'h1);
    reg_write(2'd3, 32'h0);
    wait_done(100, ctrl, irq_at);
    check_txn(base_log,     32'hFFFFFFF8, 1'b0, src_word(32'hFFFFFFF8));
    check_txn(base_log + 1, 32'h00004000, 1'b1, src_word(32'hFFFFFFF8));
    chk("abort_ntxn", 32'(log_addr.size() - base_log), 32'd2);
    chk_reg("abort_src", 2'd0, 32'hFFFFFFFC);
    chk_reg("abort_dst", 2'd1, 32'h00004004);
    chk_reg("abort_count", 2'd2, 32'd3);
    chk_reg("abort_ctrl", 2'd3, 32'h2);
    wait_n = 0;

    // Source address wraps from 0xFFFFFFFC to 0.
    base_log = log_addr.size();
    reg_write(2'd0, 32'hFFFFFFFC);
    reg_write(2'd1, 32'h00006000);
    reg_write(2'd2, 32'd2);
    reg_write(2'd3, 32'h1);
    wait_done(100, ctrl, irq_at);
    check_txn(base_log,     32'hFFFFFFFC, 1'b0, src_word(32'hFFFFFFFC));
    check_txn(base_log + 1, 32'h00006000, 1'b1, src_word(32'hFFFFFFFC));
    check_txn(base_log + 2, 32'h00000000, 1'b0, src_word(32'h00000000));
    check_txn(base_log + 3, 32'h00006004, 1'b1, src_word(32'h00000000));
    chk_reg("wrap_src", 2'd0, 32'h00000004);

    // Interrupt on completion of a single-word copy with IEN set.
    reg_write(2'd3, 32'h2);
    reg_write(2'd0, 32'h00001000);
    reg_write(2'd1, 32'h00005000);
    reg_write(2'd2, 32'd1);
    reg_write(2'd3, 32'h5);
    wait_done(100, ctrl, irq_at);
`ifdef DMA_IRQ_EN
    chk_bit("irq_at_done", irq_at, 1'b1);
    chk("irq_ctrl", ctrl, 32'h6);
`else
    chk_bit("irq_at_done", irq_at, 1'b0);
    chk("irq_ctrl", ctrl, 32'h2);
`endif
    reg_write(2'd3, 32'h2);
    chk_bit("irq_cleared", irq, 1'b0);
    chk_reg("irq_ctrl_clr", 2'd3, 32'h0);
`ifndef DMA_IRQ_EN
    chk_bit("irq_never", irq_seen, 1'b0);
`endif

    // Reset in the middle of a transfer.
    wait_n = 3;
    reg_write(2'd0, 32'h00001000);
    reg_write(2'd1, 32'h00007000);
    reg_write(2'd2, 32'd3);
    reg_write(2'd3, 32'h1);
    repeat (5) @(posedge clk);
    #1;
    chk_bit("midrst_busy_en", m_en, 1'b1);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk_bit("midrst_m_en", m_en, 1'b0);
    chk_bit("midrst_m_wr", m_wr, 1'b0);
    chk("midrst_m_addr", m_addr, 32'h0);
    chk_bit("midrst_irq", irq, 1'b0);
    base_en = en_cycles;
    chk_reg("midrst_src", 2'd0, 32'h0);
    chk_reg("midrst_count", 2'd2, 32'h0);
    chk_reg("midrst_ctrl", 2'd3, 32'h0);
    chk("midrst_en_cycles", 32'(en_cycles - base_en), 32'd0);
    wait_n = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
